min_max_disp: RTL
=================

Name: min_max_disp

Overview:
- Clocked, parametrised successor of the combinational min/max LED bar driver.
- Registers configuration (com/min/max) through a valid/ready handshake and samples the displayed value on a valid strobe.
- Generates the oscillation phase internally from a blink divider, and adds a decaying peak-hold marker.
- Drives a registered 2**VALSIZE LED vector; sits between the value source and the LED board.

Parameters:
VALSIZE, 4, width of min/max/value; LED vector is 2**VALSIZE bits
BLINK_DIV, 8, clock cycles per half-period of the internal blink phase (>=1)
HOLD_CYCLES, 16, cycles the peak marker is held without a new peak before decaying (>=1)

Ports:
clk_i  in  1  system clock, all state on rising edge
rst_ni  in  1  reset, asynchronous, active-low
com_i  in  2  mode: 00 normal, 01 linear, 10 all off, 11 all on
min_i  in  VALSIZE  lower bound of the bar (normal mode)
max_i  in  VALSIZE  upper bound of the bar (normal mode)
cfg_valid_i  in  1  com_i/min_i/max_i valid
cfg_ready_o  out  1  block can accept a configuration
val_i  in  VALSIZE  value to display
val_valid_i  in  1  val_i valid; sampled every cycle it is high
peak_en_i  in  1  enables the peak-hold marker (normal and linear modes)
leds_o  out  2**VALSIZE  registered LED vector
range_err_o  out  1  registered: normal mode and value outside [min,max]
cfg_err_o  out  1  registered: FAULT state (normal-mode config with min>max)

Behaviour:
- Reset (async, rst_ni=0): state IDLE; leds_o=0, range_err_o=0, cfg_err_o=0, cfg_ready_o=1. Config regs: com=10, min=0, max=0. Value reg=0, peak reg=0, blink counter=0, blink phase=1. Reset mid-operation aborts everything immediately.
- FSM states: IDLE, APPLY, RUN, FAULT.
  - IDLE/RUN/FAULT: cfg_ready_o=1. Handshake fires when cfg_valid_i & cfg_ready_o at a rising edge: latch com/min/max, go to APPLY.
  - APPLY: lasts exactly one cycle with cfg_ready_o=0, so back-to-back configs are accepted at most every 2 cycles. During APPLY: blink counter=0, blink phase=1, peak reg=value reg, hold counter=0. Exit to FAULT if com=00 and min>max, else to RUN.
  - FAULT: leds_o=0, cfg_err_o=1. Value sampling continues. Left only through a new accepted config.
- Value: on val_valid_i at edge k, the value reg updates at edge k. leds_o reflects it at edge k+1 (1-cycle output latency from sampled value). Without val_valid_i the value reg holds.
- Blink phase: counter counts 0..BLINK_DIV-1 in RUN. At BLINK_DIV-1 it wraps to 0 and the phase toggles. The counter is frozen in IDLE/FAULT.
- Peak, only when peak_en_i=1 in RUN:
  - If a sampled value > peak reg: peak reg=value, hold counter=0.
  - Otherwise the hold counter increments. When it reaches HOLD_CYCLES-1, peak reg=current value reg and the hold counter returns to 0.
  - When peak_en_i=0: peak reg tracks the value reg every cycle.
- LED computation (RUN), registered into leds_o; v=value, p=peak:
  - 00 normal, v in [min,max]: bits min..v = 1; bits v+1..max = blink phase; all other bits 0. If peak_en_i and v<p<=max, bit p = 1 regardless of phase.
  - 00 normal, v outside [min,max]: leds=0 and range_err_o=1.
  - 01 linear: bits 0..v = 1; if peak_en_i and p>v, bit p = 1.
  - 10: all 0.
  - 11: all 1.
  - range_err_o=0 in every mode other than 00.
- Arithmetic: all compares are unsigned VALSIZE-bit. Loop bounds must not overflow when max or v = 2**VALSIZE-1.
- IDLE: leds_o=0 until the first config is accepted.
- Simultaneous events: cfg accept and val_valid_i in the same edge both take effect. APPLY then initialises peak from the new value reg.

Test Plan (VALSIZE=4, BLINK_DIV=4, HOLD_CYCLES=8):
1. Reset low mid-RUN with leds_o non-zero -> leds_o=0, cfg_ready_o=1, both err flags 0 without a clock edge; release, no config -> leds_o stays 0.
2. Config com=00, min=3, max=12; val=8 -> cfg_ready_o=0 for exactly 1 cycle. Bits 3..8 steady 1; bits 9..12 equal phase, starting at 1 and toggling every 4 cycles; bits 0..2 and 13..15 = 0.
3. Config com=00, min=10, max=5 -> FAULT: cfg_err_o=1, leds_o=0. Then config com=01, val=15 -> RUN, cfg_err_o=0, leds_o=16'hFFFF.
4. com=00, min=0, max=15, peak_en_i=1; val 12 then 4 -> bit 12 lit with bits 0..4 steady. After 8 cycles with no higher sample, peak drops to 4 and bit 12 follows the blink phase.
5. com=00, min=4, max=9, val=2 -> leds_o=0, range_err_o=1; val=9 -> range_err_o=0, bits 4..9 =1 one cycle after sampling.
6. cfg_valid_i held high continuously with alternating com 10/11 -> accepted every 2nd cycle; leds_o alternates 16'h0000 / 16'hFFFF accordingly.

Source files
------------

// File: rtl/min_max_disp.sv
// Clocked min/max LED bar driver: handshaked configuration, sampled value,
// internal blink phase and a decaying peak-hold marker on a registered LED vector.
module min_max_disp #(
   parameter int VALSIZE     = 4,
   parameter int BLINK_DIV   = 8,
   parameter int HOLD_CYCLES = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [1:0]              com_i,
   input  logic [VALSIZE-1:0]      min_i,
   input  logic [VALSIZE-1:0]      max_i,
   input  logic                    cfg_valid_i,
   output logic                    cfg_ready_o,
   input  logic [VALSIZE-1:0]      val_i,
   input  logic                    val_valid_i,
   input  logic                    peak_en_i,
   output logic [(2**VALSIZE)-1:0] leds_o,
   output logic                    range_err_o,
   output logic                    cfg_err_o
);

   localparam int NLED = 2**VALSIZE;
   localparam int CW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int HW   = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_RUN, S_FAULT} state_t;

   state_t             state_q, state_d;
   logic [1:0]         com_q;
   logic [VALSIZE-1:0] min_q, max_q, val_q, peak_q, peak_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               phase_q, phase_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [NLED-1:0]    leds_q, leds_d;
   logic               rerr_q, rerr_d, cerr_q, cerr_d;
   logic               cfg_fire;

   // Index compares use a VALSIZE-bit copy of the loop index, so max/v at the top code never overflow.
   function automatic logic [NLED-1:0] led_map(input logic [1:0]         com,
                                                input logic [VALSIZE-1:0] mn,
                                                input logic [VALSIZE-1:0] mx,
                                                input logic [VALSIZE-1:0] v,
                                                input logic [VALSIZE-1:0] p,
                                                input logic               ph,
                                                input logic               pen);
      logic [NLED-1:0]    res;
      logic [VALSIZE-1:0] idx;
      res = '0;
      case (com)
         2'b00: begin
            if (v >= mn && v <= mx) begin
               for (int i = 0; i < NLED; i++) begin
                  idx = VALSIZE'(i);
                  if (idx >= mn && idx <= v)
                     res[i] = 1'b1;
                  else if (idx > v && idx <= mx)
                     res[i] = ph;
               end
               if (pen && p > v && p <= mx)
                  res[p] = 1'b1;
            end
         end
         2'b01: begin
            for (int i = 0; i < NLED; i++) begin
               idx = VALSIZE'(i);
               if (idx <= v)
                  res[i] = 1'b1;
            end
            if (pen && p > v)
               res[p] = 1'b1;
         end
         2'b10:   res = '0;
         default: res = '1;
      endcase
      return res;
   endfunction

   assign cfg_ready_o = (state_q != S_APPLY);
   assign cfg_fire    = cfg_valid_i & cfg_ready_o;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_APPLY: state_d = (com_q == 2'b00 && min_q > max_q) ? S_FAULT : S_RUN;
         default: if (cfg_fire) state_d = S_APPLY;
      endcase
   end

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (state_q == S_APPLY) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (state_q == S_RUN) begin
         if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      peak_d = peak_q;
      hold_d = hold_q;
      if (state_q == S_APPLY) begin
         peak_d = val_q;
         hold_d = '0;
      end else if (!peak_en_i) begin
         peak_d = val_q;
         hold_d = '0;
      end else if (state_q == S_RUN) begin
         if (val_q > peak_q) begin
            peak_d = val_q;
            hold_d = '0;
         end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            peak_d = val_q;
            hold_d = '0;
         end else begin
            hold_d = hold_q + HW'(1);
         end
      end
   end

   // Outputs hold through APPLY so a reconfiguration never flashes the bar dark.
   always_comb begin
      leds_d = leds_q;
      rerr_d = rerr_q;
      cerr_d = cerr_q;
      case (state_q)
         S_RUN: begin
            leds_d = led_map(com_q, min_q, max_q, val_q, peak_q, phase_q, peak_en_i);
            rerr_d = (com_q == 2'b00) && (val_q < min_q || val_q > max_q);
            cerr_d = 1'b0;
         end
         S_APPLY: ;
         default: begin
            leds_d = '0;
            rerr_d = 1'b0;
            cerr_d = (state_q == S_FAULT);
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         com_q   <= 2'b10;
         min_q   <= '0;
         max_q   <= '0;
         val_q   <= '0;
         peak_q  <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b1;
         hold_q  <= '0;
         leds_q  <= '0;
         rerr_q  <= 1'b0;
         cerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (cfg_fire) begin
            com_q <= com_i;
            min_q <= min_i;
            max_q <= max_i;
         end
         if (val_valid_i)
            val_q <= val_i;
         peak_q  <= peak_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         hold_q  <= hold_d;
         leds_q  <= leds_d;
         rerr_q  <= rerr_d;
         cerr_q  <= cerr_d;
      end
   end

   assign leds_o      = leds_q;
   assign range_err_o = rerr_q;
   assign cfg_err_o   = cerr_q;

endmodule
